// File: rtl/fetch_unit_16bit.sv
// fetch_unit_16bit: PC register plus req/ack instruction fetch with valid/ready handoff to decode.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit_16bit #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               PC_STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus1,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
`ifdef FETCH_STALL_CNT_EN
   output logic [WIDTH-1:0] stall_cnt,
`endif
   input  logic             instr_ready
);
   typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] instr_q;
   logic             req_q;
   logic             valid_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: if (imem_ack) begin
               instr_q <= imem_data;
               valid_q <= 1'b1;
               req_q   <= 1'b0;
               state_q <= VALID;
            end
            VALID: if (instr_ready) begin
               pc_q    <= next_pc;
               valid_q <= 1'b0;
               req_q   <= 1'b1;
               state_q <= REQ;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
`ifdef FETCH_STALL_CNT_EN
   logic [WIDTH-1:0] stall_q;
   logic             stall_d;
   // a stall is a cycle waiting on memory or on decode
   assign stall_d = (state_q == REQ && !imem_ack) || (state_q == VALID && !instr_ready);
   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else if (stall_d && stall_q != '1) stall_q <= stall_q + WIDTH'(1);
   end
   assign stall_cnt = stall_q;
`endif
   assign pc          = pc_q;
   assign pc_plus1    = pc_q + WIDTH'(PC_STEP);
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
endmodule

// File: tb/tb_fetch_unit_16bit.sv
// tb_fetch_unit_16bit: bench acting as instruction memory and decode, checked against a PC/transaction model.
module tb_fetch_unit_16bit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] next_pc = '0;
   logic [15:0] pc, pc_plus1, imem_addr, instr;
   logic        imem_req, instr_valid;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = '0;
   logic        instr_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   int checks = 0;
   int fails = 0;
   logic [15:0] exp_pc;

   fetch_unit_16bit dut (
      .clk(clk), .reset(reset), .next_pc(next_pc), .pc(pc), .pc_plus1(pc_plus1),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid),
`ifdef FETCH_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Serves one fetch starting in REQ: ack after wn idle cycles, decode stalls hn cycles, accepts with npc.
   // Records what it observed; the test tasks judge it.
   task automatic txn(input int wn, input int hn, input logic [15:0] d, input logic [15:0] npc,
                      output logic [15:0] a0, output logic [15:0] p1, output logic rs,
                      output logic [15:0] ins, output logic v, output logic hs,
                      output logic [15:0] pa, output logic ra, output int nc, output int sd);
      logic [15:0] s0;
      a0 = imem_addr; p1 = pc_plus1; rs = 1'b1; hs = 1'b1; nc = 0; sd = 0; s0 = '0;
`ifdef FETCH_STALL_CNT_EN
      s0 = stall_cnt;
`endif
      for (int i = 0; i <= wn; i++) begin
         if (!(imem_req === 1'b1 && imem_addr === a0 && instr_valid === 1'b0)) rs = 1'b0;
         imem_ack = (i == wn);
         imem_data = (i == wn) ? d : 16'($urandom);
         instr_ready = 1'($urandom);
         next_pc = 16'($urandom);
         tick(); nc++;
      end
      ins = instr; v = instr_valid;
      if (imem_req !== 1'b0) hs = 1'b0;
      for (int i = 0; i < hn; i++) begin
         instr_ready = 1'b0; next_pc = 16'($urandom); imem_ack = 1'($urandom); imem_data = 16'($urandom);
         tick(); nc++;
         if (instr !== ins || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== a0) hs = 1'b0;
      end
      instr_ready = 1'b1; next_pc = npc; imem_ack = 1'($urandom);
`ifdef FETCH_STALL_CNT_EN
      sd = int'(stall_cnt) - int'(s0);
`endif
      tick(); nc++;
      pa = pc; ra = imem_req;
      if (instr_valid !== 1'b0 || imem_addr !== npc) hs = 1'b0;
      instr_ready = 1'b0; imem_ack = 1'b0; next_pc = 16'($urandom);
   endtask

   task automatic test_reset();
      imem_ack = 1'b1; imem_data = 16'hBEEF; instr_ready = 1'b1;
      tick(); tick();
      checks += 4;
      if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      if (instr !== 16'h0000) begin fails++; $display("FAIL reset_instr got=%h exp=0000", instr); end
      reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
      tick();
      checks += 2;
      if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req got=%b exp=1", imem_req); end
      if (imem_addr !== 16'h0000) begin fails++; $display("FAIL first_addr got=%h exp=0000", imem_addr); end
      exp_pc = 16'h0000;
   endtask

   task automatic test_sequential();
      logic [15:0] a0, p1, ins, pa, d; logic rs, v, hs, ra; int nc, sd;
      for (int k = 0; k < 4; k++) begin
         d = 16'($urandom);
         txn(0, 0, d, exp_pc + 16'd1, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
         checks += 6;
         if (a0 !== 16'(k)) begin fails++; $display("FAIL seq_addr got=%h exp=%h", a0, 16'(k)); end
         if (p1 !== 16'(k + 1)) begin fails++; $display("FAIL seq_pc_plus1 got=%h exp=%h", p1, 16'(k + 1)); end
         if (ins !== d || v !== 1'b1) begin fails++; $display("FAIL seq_instr got=%h/%b exp=%h/1", ins, v, d); end
         if (nc !== 2) begin fails++; $display("FAIL seq_cycles got=%0d exp=2", nc); end
         if (rs !== 1'b1 || hs !== 1'b1) begin fails++; $display("FAIL seq_handshake got=%b%b exp=11", rs, hs); end
         if (pa !== 16'(k + 1) || ra !== 1'b1) begin fails++; $display("FAIL seq_next got=%h/%b exp=%h/1", pa, ra, 16'(k + 1)); end
         exp_pc = exp_pc + 16'd1;
      end
   endtask

   task automatic test_wait_ack();
      logic [15:0] a0, p1, ins, pa, d; logic rs, v, hs, ra; int nc, sd;
      d = 16'hC3A5;
      txn(2, 0, d, 16'h0005, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks += 4;
      if (a0 !== 16'h0004) begin fails++; $display("FAIL wait_addr got=%h exp=0004", a0); end
      if (rs !== 1'b1) begin fails++; $display("FAIL wait_req_stable got=%b exp=1", rs); end
      if (ins !== d || v !== 1'b1) begin fails++; $display("FAIL wait_instr got=%h/%b exp=%h/1", ins, v, d); end
      if (nc !== 4) begin fails++; $display("FAIL wait_cycles got=%0d exp=4", nc); end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (sd !== 2) begin fails++; $display("FAIL wait_stall got=%0d exp=2", sd); end
`endif
      exp_pc = 16'h0005;
   endtask

   task automatic test_decode_stall();
      logic [15:0] a0, p1, ins, pa; logic rs, v, hs, ra; int nc, sd;
      txn(0, 4, 16'h1234, 16'h0006, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks += 4;
      if (ins !== 16'h1234) begin fails++; $display("FAIL stall_instr got=%h exp=1234", ins); end
      if (hs !== 1'b1) begin fails++; $display("FAIL stall_hold got=%b exp=1", hs); end
      if (pa !== 16'h0006 || ra !== 1'b1) begin fails++; $display("FAIL stall_accept got=%h/%b exp=0006/1", pa, ra); end
      if (nc !== 6) begin fails++; $display("FAIL stall_cycles got=%0d exp=6", nc); end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (sd !== 4) begin fails++; $display("FAIL stall_cnt got=%0d exp=4", sd); end
`endif
      exp_pc = 16'h0006;
   endtask

   task automatic test_branch();
      logic [15:0] a0, p1, ins, pa; logic rs, v, hs, ra; int nc, sd;
      txn(0, 0, 16'h0F0F, 16'd1000, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks++;
      if (pa !== 16'd1000) begin fails++; $display("FAIL branch_pc got=%h exp=%h", pa, 16'd1000); end
      txn(1, 0, 16'h7777, 16'd1001, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks += 2;
      if (a0 !== 16'd1000) begin fails++; $display("FAIL branch_addr got=%h exp=%h", a0, 16'd1000); end
      if (p1 !== 16'd1001) begin fails++; $display("FAIL branch_pc_plus1 got=%h exp=%h", p1, 16'd1001); end
      exp_pc = 16'd1001;
   endtask

   task automatic test_wrap();
      logic [15:0] a0, p1, ins, pa; logic rs, v, hs, ra; int nc, sd;
      txn(0, 0, 16'h1111, 16'hFFFF, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      txn(0, 0, 16'h2222, 16'h0000, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks += 3;
      if (a0 !== 16'hFFFF) begin fails++; $display("FAIL wrap_addr got=%h exp=ffff", a0); end
      if (p1 !== 16'h0000) begin fails++; $display("FAIL wrap_pc_plus1 got=%h exp=0000", p1); end
      if (pa !== 16'h0000) begin fails++; $display("FAIL wrap_pc got=%h exp=0000", pa); end
      txn(0, 1, 16'h3333, 16'h0001, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
      checks++;
      if (a0 !== 16'h0000 || ins !== 16'h3333) begin fails++; $display("FAIL wrap_refetch got=%h/%h exp=0000/3333", a0, ins); end
      exp_pc = 16'h0001;
   endtask

   task automatic test_random();
      logic [15:0] a0, p1, ins, pa, d, npc; logic rs, v, hs, ra; int nc, sd, wn, hn;
      for (int k = 0; k < 30; k++) begin
         wn = int'($urandom_range(0, 3)); hn = int'($urandom_range(0, 3)); d = 16'($urandom);
         npc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'((32'(exp_pc) + 1) % 65536);
         txn(wn, hn, d, npc, a0, p1, rs, ins, v, hs, pa, ra, nc, sd);
         checks += 5;
         if (a0 !== exp_pc) begin fails++; $display("FAIL rnd_addr got=%h exp=%h", a0, exp_pc); end
         if (p1 !== 16'((32'(exp_pc) + 1) % 65536)) begin fails++; $display("FAIL rnd_pc_plus1 got=%h exp=%h", p1, exp_pc + 16'd1); end
         if (ins !== d || v !== 1'b1 || rs !== 1'b1) begin fails++; $display("FAIL rnd_instr got=%h/%b/%b exp=%h/1/1", ins, v, rs, d); end
         if (hs !== 1'b1 || pa !== npc || ra !== 1'b1) begin fails++; $display("FAIL rnd_accept got=%b/%h/%b exp=1/%h/1", hs, pa, ra, npc); end
         if (nc !== wn + hn + 2) begin fails++; $display("FAIL rnd_cycles got=%0d exp=%0d", nc, wn + hn + 2); end
`ifdef FETCH_STALL_CNT_EN
         checks++;
         if (sd !== wn + hn) begin fails++; $display("FAIL rnd_stall got=%0d exp=%0d", sd, wn + hn); end
`endif
         exp_pc = npc;
      end
   endtask

   task automatic test_reset_mid();
      imem_ack = 1'b1; imem_data = 16'hABCD; reset = 1'b1;
      tick();
      checks += 4;
      if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got=%b exp=0", instr_valid); end
      if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req_req got=%b exp=0", imem_req); end
      if (pc !== 16'h0000) begin fails++; $display("FAIL rst_req_pc got=%h exp=0000", pc); end
      if (instr !== 16'h0000) begin fails++; $display("FAIL rst_req_instr got=%h exp=0000", instr); end
      reset = 1'b0; imem_ack = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++; $display("FAIL rst_refetch got=%b/%h exp=1/0000", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_data = 16'h5555;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h5555) begin fails++; $display("FAIL rst_fetch got=%b/%h exp=1/5555", instr_valid, instr); end
      reset = 1'b1; instr_ready = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0000) begin fails++; $display("FAIL rst_valid got=%b/%b/%h exp=0/0/0000", instr_valid, imem_req, pc); end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 16'h0000) begin fails++; $display("FAIL rst_stall got=%h exp=0000", stall_cnt); end
`endif
      reset = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++; $display("FAIL rst_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_ack();
      test_decode_stall();
      test_branch();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit_16bit.md
Name: fetch_unit_16bit

Overview:
- Program-counter and instruction-fetch stage for the 16-bit MIPS datapath. Sits directly downstream of mux2x1_16bit next-PC select.
- Drives pc_plus1 into mux input i0; the branch target drives mux i1; the mux output y returns as next_pc.
- Holds PC, handshakes with instruction memory (req/ack), and presents each fetched instruction to decode over valid/ready.

Parameters:
WIDTH, 16, datapath and address width
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 1, increment for pc_plus1 (word-addressed instruction memory)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
next_pc  input  WIDTH  next PC from mux2x1_16bit output y
pc  output  WIDTH  current PC (registered)
pc_plus1  output  WIDTH  pc + PC_STEP, combinational, to mux i0
imem_req  output  1  fetch request to instruction memory (registered)
imem_addr  output  WIDTH  fetch address, equals pc
imem_ack  input  1  memory has returned data this cycle
imem_data  input  WIDTH  instruction word, valid when imem_ack=1
instr  output  WIDTH  captured instruction to decode (registered)
instr_valid  output  1  instr is valid (registered)
instr_ready  input  1  decode accepts instr

Behaviour:
- Reset: the following values apply on the clock edge where reset=1. Reset overrides all other inputs.
  - pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, state=IDLE.
  - An ack pending at reset is discarded.
- FSM states: IDLE, REQ, VALID.
  - IDLE: next edge -> REQ, imem_req<=1. Lasts exactly 1 cycle after reset deasserts.
  - REQ: imem_req=1 and imem_addr=pc are held stable until ack.
    - On an edge with imem_ack=1: instr<=imem_data, instr_valid<=1, imem_req<=0, -> VALID.
    - imem_ack=0: remain in REQ. No timeout.
  - VALID: instr and instr_valid are held stable while instr_ready=0.
    - On an edge with instr_ready=1: pc<=next_pc, instr_valid<=0, imem_req<=1, -> REQ.
- next_pc is sampled only on the VALID-accept edge. It is ignored at all other times, so the mux select may settle any time during VALID.
- imem_ack is ignored outside REQ. imem_data is ignored unless imem_ack=1 in REQ.
- instr_ready is ignored outside VALID.
- Latency:
  - The first request is asserted 1 cycle after reset release.
  - With zero-wait memory (ack in the first REQ cycle) and decode always ready, each instruction takes 2 cycles: 1 REQ + 1 VALID.
- Arithmetic:
  - pc_plus1 = (pc + PC_STEP) mod 2^WIDTH. 16'hFFFF + 1 wraps to 16'h0000 with no flag.
  - next_pc is loaded as-is, with no alignment check.
- Reset mid-operation (in REQ with imem_ack pending, or in VALID with instr_valid=1): return to IDLE, drop instr_valid and imem_req on that edge. The memory must tolerate a withdrawn request.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (WIDTH).
  - Increments by 1 on each cycle spent in REQ with imem_ack=0, or in VALID with instr_ready=0.
  - Saturates at 16'hFFFF.
  - Resets to 0 with reset.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset release; memory acks in the first REQ cycle; instr_ready=1; next_pc looped from pc_plus1 -> imem_addr sequence 0,1,2,3; instr_valid pulses every 2nd cycle; instr equals the imem_data returned for each address.
- Memory acks 3 cycles after req -> imem_req and imem_addr=16'h0004 stay stable for 3 cycles; instr captured only on the ack edge; with FETCH_STALL_CNT_EN, stall_cnt=2.
- Decode holds instr_ready=0 for 4 cycles with instr=16'h1234 -> instr and instr_valid unchanged; pc unchanged; no new imem_req until ready=1.
- Branch: at accept, next_pc=16'd1000 (mux select=1, i1=1000) -> next imem_addr=1000; pc_plus1=1001.
- Wrap: pc=16'hFFFF -> pc_plus1=16'h0000; looping next_pc fetches address 0.
- Reset asserted in REQ while imem_ack=1 -> instr_valid stays 0; pc=RESET_PC; instr=0; refetch starts from RESET_PC.
